axi_sync_packet_fifo: RTL and testbench

Single-clock, store-and-forward AXI-Stream packet FIFO for the MAC/UDP datapath. It is the synchronous, parametrised successor to the async frame FIFO, used where both sides share a clock (for example between the UDP/IP stack and the MAC TX path). Beats become visible downstream only after a good `tlast`. Bad frames (`tuser` set) are discarded, and overflowing or oversized frames are dropped. Occupancy, frame-count, threshold and event outputs are provided for flow control and statistics.

---
 rtl/axi_sync_packet_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_sync_packet_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sync_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_sync_packet_fifo
// Description : Single-clock store-and-forward AXI-Stream packet FIFO.
//               A frame becomes visible downstream only after its tlast beat
//               arrives with tuser clear. Frames marked bad are rewound away.
//               A frame that overflows the FIFO, or that cannot fit even in an
//               empty FIFO, is dropped.
// Ports       : clk, sreset           - clock, synchronous active-high reset
//               s_axis_*              - write-side AXI-Stream slave
//               m_axis_*              - read-side AXI-Stream master
//               o_occupancy           - committed words not yet fetched
//               o_frame_count         - committed frames not yet fully read
//               o_almost_full/empty   - threshold flags
//               o_good_frame/o_bad_frame/o_overflow - one-cycle event pulses
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sync_packet_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int KEEP_ENABLE         = 0,
    parameter int ADDR_WIDTH          = 9,
    parameter int FRAME_DROP_EN       = 0,
    parameter int ALMOST_FULL_THRESH  = (2**ADDR_WIDTH) - 16,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_trdy,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_trdy,
    output logic [ADDR_WIDTH:0]     o_occupancy,
    output logic [ADDR_WIDTH:0]     o_frame_count,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic                    o_good_frame,
    output logic                    o_bad_frame,
    output logic                    o_overflow
);

    localparam int c_KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int c_DEPTH      = 2**ADDR_WIDTH;
    localparam int c_PTR_W      = ADDR_WIDTH + 1;
    localparam int c_KEEP_BITS  = (KEEP_ENABLE != 0) ? c_KEEP_WIDTH : 0;
    localparam int c_WORD_W     = DATA_WIDTH + c_KEEP_BITS + 1;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_t;

    wr_state_t            r_state;
    wr_state_t            w_state_nxt;

    logic [c_WORD_W-1:0]  r_mem [c_DEPTH];
    logic [c_WORD_W-1:0]  r_out_word;
    logic [c_WORD_W-1:0]  w_wr_word;

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_wr_commit;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_frame_cnt;
    logic                 r_m_valid;
    logic                 r_good;
    logic                 r_bad;
    logic                 r_ovf;

    logic [c_PTR_W-1:0]   w_fill;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_s_trdy;
    logic                 w_wr_en;
    logic                 w_commit;
    logic                 w_discard_bad;
    logic                 w_rewind_drop;
    logic                 w_ovf_evt;
    logic                 w_fetch;
    logic                 w_out_last_hs;

    // Flags come from registered pointers only; a slot freed by a read this
    // cycle is not writable until the next one.
    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_fill == c_PTR_W'(c_DEPTH));
    assign w_empty = (r_rd_ptr == r_wr_commit);

    // Stored word layout: {tdata, tkeep (optional), tlast}
    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign w_wr_word    = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
            assign m_axis_tkeep = r_out_word[c_KEEP_WIDTH:1];
        end else begin : g_no_keep
            logic w_unused_keep;
            assign w_unused_keep = ^s_axis_tkeep;
            assign w_wr_word     = {s_axis_tdata, s_axis_tlast};
            assign m_axis_tkeep  = {c_KEEP_WIDTH{1'b1}};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_commit      = 1'b0;
        w_discard_bad = 1'b0;
        w_rewind_drop = 1'b0;
        w_ovf_evt     = 1'b0;
        // In drop mode the FIFO is always ready; the beat that finds it full
        // is taken and thrown away along with the rest of its frame.
        w_s_trdy      = !sreset && ((r_state == ST_DROP) || !w_full || (FRAME_DROP_EN != 0));
        case (r_state)
            ST_ACCEPT: begin
                if (s_axis_tvalid && w_full &&
                    ((FRAME_DROP_EN != 0) || (r_wr_commit == r_rd_ptr))) begin
                    w_rewind_drop = 1'b1;
                    // A full-entry beat that is itself the tlast closes the
                    // frame immediately, so DROP would never see its end.
                    if (w_s_trdy && s_axis_tlast) begin
                        w_ovf_evt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (s_axis_tvalid && w_s_trdy) begin
                    w_wr_en = 1'b1;
                    if (s_axis_tlast) begin
                        w_commit      = !s_axis_tuser;
                        w_discard_bad = s_axis_tuser;
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && w_s_trdy && s_axis_tlast) begin
                    w_ovf_evt   = 1'b1;
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_good      <= 1'b0;
            r_bad       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_rewind_drop || w_discard_bad) begin
                r_wr_ptr <= r_wr_commit;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
            end
            r_good <= w_commit;
            r_bad  <= w_discard_bad;
            r_ovf  <= w_ovf_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------------
    // Read side: single output register
    // ------------------------------------------------------------------------
    assign w_fetch       = !w_empty && (!r_m_valid || m_axis_trdy);
    assign w_out_last_hs = r_m_valid && m_axis_trdy && r_out_word[0];

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_rd_ptr   <= '0;
            r_m_valid  <= 1'b0;
            r_out_word <= '0;
        end else if (w_fetch) begin
            r_out_word <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_m_valid  <= 1'b1;
        end else if (r_m_valid && m_axis_trdy) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_frame_cnt <= '0;
        end else if (w_commit && !w_out_last_hs) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end else if (!w_commit && w_out_last_hs) begin
            r_frame_cnt <= r_frame_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axis_trdy    = w_s_trdy;
    assign m_axis_tdata   = r_out_word[c_WORD_W-1 -: DATA_WIDTH];
    assign m_axis_tlast   = r_out_word[0];
    assign m_axis_tvalid  = r_m_valid;
    assign o_occupancy    = r_wr_commit - r_rd_ptr;
    assign o_frame_count  = r_frame_cnt;
    assign o_almost_full  = (w_fill >= c_PTR_W'(ALMOST_FULL_THRESH));
    assign o_almost_empty = (o_occupancy <= c_PTR_W'(ALMOST_EMPTY_THRESH));
    assign o_good_frame   = r_good;
    assign o_bad_frame    = r_bad;
    assign o_overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_axi_sync_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sync_packet_fifo
// Description : Self-checking bench for axi_sync_packet_fifo. Two instances
//               (backpressure mode without keep, drop mode with keep) share
//               the input stimulus; a select picks the one under test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sync_packet_fifo;

    localparam int c_AW = 4;

    logic       clk = 1'b0;
    logic       sreset = 1'b1;
    logic [7:0] s_tdata = '0;
    logic [0:0] s_tkeep = '0;
    logic       s_tlast = 1'b0;
    logic       s_tuser = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       m_trdy = 1'b0;
    logic       sel = 1'b0;

    logic       s_trdy0, s_trdy1;
    logic [7:0] m_tdata0, m_tdata1;
    logic [0:0] m_tkeep0, m_tkeep1;
    logic       m_tlast0, m_tlast1, m_tvalid0, m_tvalid1;
    logic [c_AW:0] occ0, occ1, fc0, fc1;
    logic       af0, af1, ae0, ae1, gf0, gf1, bf0, bf1, ov0, ov1;

    always #5 clk = ~clk;

    axi_sync_packet_fifo #(
        .DATA_WIDTH(8), .KEEP_ENABLE(0), .ADDR_WIDTH(c_AW), .FRAME_DROP_EN(0),
        .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(4)
    ) u_dut0 (
        .clk(clk), .sreset(sreset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_trdy(s_trdy0),
        .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tlast(m_tlast0),
        .m_axis_tvalid(m_tvalid0), .m_axis_trdy(m_trdy),
        .o_occupancy(occ0), .o_frame_count(fc0), .o_almost_full(af0),
        .o_almost_empty(ae0), .o_good_frame(gf0), .o_bad_frame(bf0), .o_overflow(ov0)
    );

    axi_sync_packet_fifo #(
        .DATA_WIDTH(8), .KEEP_ENABLE(1), .ADDR_WIDTH(c_AW), .FRAME_DROP_EN(1),
        .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(4)
    ) u_dut1 (
        .clk(clk), .sreset(sreset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_trdy(s_trdy1),
        .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tlast(m_tlast1),
        .m_axis_tvalid(m_tvalid1), .m_axis_trdy(m_trdy),
        .o_occupancy(occ1), .o_frame_count(fc1), .o_almost_full(af1),
        .o_almost_empty(ae1), .o_good_frame(gf1), .o_bad_frame(bf1), .o_overflow(ov1)
    );

    // Selected instance
    wire        w_trdy  = sel ? s_trdy1   : s_trdy0;
    wire        w_valid = sel ? m_tvalid1 : m_tvalid0;
    wire [7:0]  w_data  = sel ? m_tdata1  : m_tdata0;
    wire        w_keep  = sel ? m_tkeep1[0] : m_tkeep0[0];
    wire        w_last  = sel ? m_tlast1  : m_tlast0;
    wire [c_AW:0] w_occ = sel ? occ1 : occ0;
    wire [c_AW:0] w_fc  = sel ? fc1  : fc0;
    wire        w_af    = sel ? af1 : af0;
    wire        w_ae    = sel ? ae1 : ae0;
    wire        w_gf    = sel ? gf1 : gf0;
    wire        w_bf    = sel ? bf1 : bf0;
    wire        w_ov    = sel ? ov1 : ov0;

    typedef struct { logic [7:0] d; logic l; } exp_t;
    typedef struct { int len; int base; bit bad; } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_good = 0;
    int   n_bad = 0;
    int   n_ovf = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor / scoreboard consumer and event pulse counter
    always @(negedge clk) begin
        if (!sreset) begin
            if (w_gf) n_good++;
            if (w_bf) n_bad++;
            if (w_ov) n_ovf++;
            if (w_valid && m_trdy) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", {w_last, w_data}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", w_data, e.d);
                    check("out_last", w_last, e.l);
                    check("out_keep", w_keep, sel ? e.d[0] : 1'b1);
                end
            end
        end
    end

    task automatic clr_counts();
        n_good = 0; n_bad = 0; n_ovf = 0; stall_cnt = 0;
    endtask

    task automatic put_beat(input logic [7:0] d, input logic last, input logic user, input bit push);
        int t;
        t = 0;
        s_tdata = d; s_tkeep = d[0]; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
        @(negedge clk);
        while (!w_trdy && t < 200) begin
            t++;
            @(negedge clk);
        end
        stall_cnt += t;
        if (t >= 200) begin
            check("beat_timeout", t, 0);
        end else begin
            @(posedge clk); #1;
            if (push) sb.push_back('{d, last});
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit bad, input bit push);
        for (int i = 0; i < len; i++) begin
            put_beat(8'(base + i), (i == len - 1), bad && (i == len - 1), push);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || w_valid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        sreset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        sb.delete();
        sreset = 1'b0;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [6];

    initial begin
        int exp_good;
        int exp_bad;

        // ---------------- reset values ----------------
        sel = 1'b0;
        sreset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_s_trdy", w_trdy, 0);
        check("rst_m_tvalid", w_valid, 0);
        check("rst_occupancy", w_occ, 0);
        check("rst_frame_count", w_fc, 0);
        check("rst_almost_empty", w_ae, 1);
        check("rst_almost_full", w_af, 0);
        check("rst_pulses", {w_gf, w_bf, w_ov}, 0);
        sreset = 1'b0;
        #1;
        check("rst_s_trdy_after", w_trdy, 1);

        // ---------------- basic commit and latency ----------------
        @(posedge clk); #1;
        clr_counts();
        m_trdy = 1'b1;
        send_frame(5, 'h10, 1'b0, 1'b1);
        check("lat_tvalid_n", w_valid, 0);
        check("lat_good_pulse", w_gf, 1);
        check("lat_frame_count", w_fc, 1);
        @(posedge clk); #1;
        check("lat_tvalid_n1", w_valid, 1);
        check("lat_first_data", w_data, 8'h10);
        check("lat_good_pulse_end", w_gf, 0);
        wait_drain();
        check("basic_frame_count", w_fc, 0);
        check("basic_good_cnt", n_good, 1);

        // ---------------- table of frames, streaming ----------------
        vecs[0] = '{3,  'h30, 1'b1};
        vecs[1] = '{2,  'hA0, 1'b0};
        vecs[2] = '{1,  'h55, 1'b0};
        vecs[3] = '{7,  'h60, 1'b0};
        vecs[4] = '{4,  'h70, 1'b1};
        vecs[5] = '{16, 'h80, 1'b0};
        clr_counts();
        exp_good = 0;
        exp_bad = 0;
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].len, vecs[v].base, vecs[v].bad, !vecs[v].bad);
            if (vecs[v].bad) exp_bad++; else exp_good++;
            wait_drain();
            repeat (2) begin @(posedge clk); #1; end
            check("vec_occupancy", w_occ, 0);
        end
        check("vec_good_cnt", n_good, exp_good);
        check("vec_bad_cnt", n_bad, exp_bad);
        check("vec_frame_count", w_fc, 0);

        // ---------------- backpressure at full ----------------
        sel = 1'b0;
        do_reset();
        clr_counts();
        m_trdy = 1'b0;
        send_frame(10, 'hB0, 1'b0, 1'b1);
        send_frame(6, 'hC0, 1'b0, 1'b1);
        // one word sits in the output register, so the array holds 15
        check("bp_trdy_15", w_trdy, 1);
        check("bp_occ_15", w_occ, 15);
        check("bp_almost_full", w_af, 1);
        check("bp_almost_empty", w_ae, 0);
        check("bp_frame_count", w_fc, 2);
        send_frame(1, 'hD0, 1'b0, 1'b1);
        check("bp_trdy_full", w_trdy, 0);
        check("bp_occ_full", w_occ, 16);
        s_tdata = 8'hE0; s_tlast = 1'b1; s_tvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("bp_hold_trdy", w_trdy, 0);
        check("bp_hold_occ", w_occ, 16);
        fork
            put_beat(8'hE0, 1'b1, 1'b0, 1'b1);
            begin @(posedge clk); #1; m_trdy = 1'b1; end
        join
        wait_drain();
        check("bp_good_cnt", n_good, 4);
        check("bp_fc_end", w_fc, 0);

        // ---------------- oversized frame, backpressure mode ----------------
        do_reset();
        clr_counts();
        m_trdy = 1'b1;
        send_frame(20, 'h40, 1'b0, 1'b0);
        check("ovs_ovf_pulse", w_ov, 1);
        @(posedge clk); #1;
        check("ovs_ovf_cnt", n_ovf, 1);
        check("ovs_occupancy", w_occ, 0);
        check("ovs_tvalid", w_valid, 0);
        send_frame(2, 'h90, 1'b0, 1'b1);
        wait_drain();
        check("ovs_good_cnt", n_good, 1);

        // ---------------- overflow drop, drop mode ----------------
        sel = 1'b1;
        do_reset();
        clr_counts();
        m_trdy = 1'b0;
        send_frame(12, 'h20, 1'b0, 1'b1);
        send_frame(8, 'h50, 1'b0, 1'b0);
        check("drop_no_stall", stall_cnt, 0);
        @(posedge clk); #1;
        check("drop_ovf_cnt", n_ovf, 1);
        check("drop_good_cnt", n_good, 1);
        check("drop_occupancy", w_occ, 11);
        check("drop_frame_count", w_fc, 1);
        m_trdy = 1'b1;
        wait_drain();
        check("drop_fc_end", w_fc, 0);

        // ---------------- reset mid-frame ----------------
        sel = 1'b0;
        do_reset();
        m_trdy = 1'b0;
        send_frame(2, 'h31, 1'b0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        put_beat(8'h61, 1'b0, 1'b0, 1'b0);
        put_beat(8'h62, 1'b0, 1'b0, 1'b0);
        s_tdata = 8'h63; s_tlast = 1'b0; s_tvalid = 1'b1;
        sreset = 1'b1;
        @(negedge clk);
        check("mid_rst_trdy", w_trdy, 0);
        @(posedge clk); #1;
        sreset = 1'b0;
        s_tvalid = 1'b0;
        sb.delete();
        #1;
        check("mid_tvalid", w_valid, 0);
        check("mid_occupancy", w_occ, 0);
        check("mid_frame_count", w_fc, 0);
        check("mid_trdy_after", w_trdy, 1);
        clr_counts();
        m_trdy = 1'b1;
        send_frame(3, 'h71, 1'b0, 1'b1);
        wait_drain();
        check("mid_good_cnt", n_good, 1);
        check("mid_bad_ovf_cnt", n_bad + n_ovf, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
